store_rmw_ctrl: RTL and testbench

- Sequences sub-word stores (sb/sh) as a read-modify-write on the word-wide data memory.
- Sits between the multicycle control unit and the data memory.
- Reads the target word, merges the byte or halfword into the addressed lane, writes the word back, then pulses done.
- Word stores (sw) skip the read phase.

---
 rtl/store_pkg.sv | 25 ++
 rtl/store_lane_merge.sv | 32 +++
 rtl/store_rmw_ctrl.sv | 122 ++++++++++++
 tb/tb_store_rmw_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types and constants for the sub-word store read-modify-write sequencer.
package store_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } store_size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } store_state_t;

    // The reserved encoding 2'b11 behaves as a full-word store.
    function automatic store_size_t decode_size(input logic [1:0] raw);
        return (raw == 2'b11) ? SZ_WORD : store_size_t'(raw);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Merges a byte or halfword into the addressed lane of a word; word size passes new_data through.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] new_data,
    input  store_size_t       size,
    input  logic [1:0]        lane,
    output logic [WORD_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    default: merged[31:24] = new_data[7:0];
                endcase
            end
            // lane[0] is deliberately ignored for halfwords
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = new_data[15:0];
                else         merged[15:0]  = new_data[15:0];
            end
            default: merged = new_data;
        endcase
    end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Sequences sb/sh as read-modify-write on word memory; sw skips the read. Optional STORE_RMW_ALIGN_CHECK_EN rejects odd halfwords.
// States: IDLE wait start | READ strobe mem_rd | WAIT count RD_LAT | WRITE strobe mem_wr | DONE pulse done.
module store_rmw_ctrl
    import store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
`ifdef STORE_RMW_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

    store_state_t      r_state;
    store_state_t      w_next_state;
    store_size_t       r_size;
    store_size_t       w_size_in;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdbuf;
    logic [2:0]        r_wait_cnt;
    logic [WORD_W-1:0] w_merged;
    logic              w_capture;
    logic              w_misalign_req;

    assign w_size_in = decode_size(size);
    assign w_capture = (r_state == IDLE) && start;

`ifdef STORE_RMW_ALIGN_CHECK_EN
    logic r_misalign;
    assign w_misalign_req = (w_size_in == SZ_HALF) && addr[0];
    assign misalign       = (r_state == DONE) && r_misalign;
`else
    assign w_misalign_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_size     <= SZ_BYTE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdbuf    <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_size  <= w_size_in;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == READ) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_state == WAIT && r_wait_cnt != 3'd0) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            if (r_state == WAIT && r_wait_cnt == 3'd0) begin
                r_rdbuf <= mem_rdata;
            end
        end
    end

`ifdef STORE_RMW_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (w_capture) begin
            r_misalign <= w_misalign_req;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_misalign_req)           w_next_state = DONE;
                    else if (w_size_in == SZ_WORD) w_next_state = WRITE;
                    else                           w_next_state = READ;
                end
            end
            READ:    w_next_state = WAIT;
            WAIT:    if (r_wait_cnt == 3'd0) w_next_state = WRITE;
            WRITE:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    store_lane_merge u_merge (
        .old_word (r_rdbuf),
        .new_data (r_wdata),
        .size     (r_size),
        .lane     (r_addr[1:0]),
        .merged   (w_merged)
    );

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign mem_rd    = (r_state == READ);
    assign mem_wr    = (r_state == WRITE);
    assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata = (r_state == WRITE) ? w_merged : '0;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Scoreboard bench: two DUTs (RD_LAT=1 and RD_LAT=3) share stimulus; a negedge monitor checks strobes, merged data and latency.
`timescale 1ns/1ps
module tb_store_rmw_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          nrd;
        int          nwr;
        int          lat;
        int          start_cyc;
        bit          mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy [2];
    logic        done [2];
    logic        mem_rd [2];
    logic        mem_wr [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
`ifdef STORE_RMW_ALIGN_CHECK_EN
    logic        misalign [2];
`endif

    int          lats [2] = '{1, 3};
    exp_t        sb [2][$];
    logic [31:0] mem [2][256];
    int          rd_cnt [2] = '{0, 0};
    int          wr_cnt [2] = '{0, 0};
    int          rd_due [2] = '{-1, -1};
    logic [7:0]  rd_idx [2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    store_rmw_ctrl #(.ADDR_W(32), .RD_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy[0]), .done(done[0]), .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]),
        .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
`ifdef STORE_RMW_ALIGN_CHECK_EN
        , .misalign(misalign[0])
`endif
    );

    store_rmw_ctrl #(.ADDR_W(32), .RD_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy[1]), .done(done[1]), .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]),
        .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
`ifdef STORE_RMW_ALIGN_CHECK_EN
        , .misalign(misalign[1])
`endif
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h, want %h", name, idx, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int idx);
        checks++;
        errors++;
        $display("FAIL %s dut%0d cycle %0d: got an event, want none", name, idx, cyc);
    endtask

    // Memory model and scoreboard monitor
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mem_rdata[i] = (cyc == rd_due[i]) ? mem[i][rd_idx[i]] : 32'h5A5A_5A5A;
            if (mem_rd[i] === 1'b1) begin
                rd_cnt[i]++;
                rd_due[i] = cyc + lats[i];
                rd_idx[i] = mem_addr[i][9:2];
                chk("rd_wr_exclusive", i, {31'd0, mem_wr[i]}, 32'd0);
                if (sb[i].size() == 0) unexpected("stray_mem_rd", i);
                else chk("rd_addr", i, mem_addr[i], sb[i][0].addr);
            end
            if (mem_wr[i] === 1'b1) begin
                wr_cnt[i]++;
                if (sb[i].size() == 0) unexpected("stray_mem_wr", i);
                else begin
                    chk("wr_addr", i, mem_addr[i], sb[i][0].addr);
                    chk("wr_data", i, mem_wdata[i], sb[i][0].data);
                end
                mem[i][mem_addr[i][9:2]] = mem_wdata[i];
            end
            if (done[i] === 1'b1) begin
                if (sb[i].size() == 0) unexpected("stray_done", i);
                else begin
                    chk("latency", i, 32'(cyc - sb[i][0].start_cyc), 32'(sb[i][0].lat - 1));
                    chk("read_count", i, 32'(rd_cnt[i]), 32'(sb[i][0].nrd));
                    chk("write_count", i, 32'(wr_cnt[i]), 32'(sb[i][0].nwr));
                    chk("busy_in_done", i, {31'd0, busy[i]}, 32'd1);
`ifdef STORE_RMW_ALIGN_CHECK_EN
                    chk("misalign", i, {31'd0, misalign[i]}, {31'd0, sb[i][0].mis});
`endif
                    void'(sb[i].pop_front());
                end
                rd_cnt[i] = 0;
                wr_cnt[i] = 0;
            end
        end
    end

    task automatic preset(input logic [31:0] a, input logic [31:0] v);
        mem[0][a[9:2]] = v;
        mem[1][a[9:2]] = v;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: pending %0d/%0d, want 0/0", sb[0].size(), sb[1].size());
            sb[0].delete();
            sb[1].delete();
        end
    endtask

    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_data, input bit mis, input bit wait_end);
        exp_t e;
        bit   rmw;
        @(posedge clk); #1;
        start = 1'b1; size = sz; addr = a; wdata = d;
        rmw = (sz == 2'b00 || sz == 2'b01) && !mis;
        for (int i = 0; i < 2; i++) begin
            e.addr      = {a[31:2], 2'b00};
            e.data      = exp_data;
            e.mis       = mis;
            e.nrd       = rmw ? 1 : 0;
            e.nwr       = mis ? 0 : 1;
            e.lat       = mis ? 2 : (rmw ? lats[i] + 4 : 3);
            e.start_cyc = cyc;
            sb[i].push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        size  = 2'($urandom_range(3, 0));
        addr  = $urandom;
        wdata = $urandom;
        if (wait_end) wait_idle();
    endtask

    task automatic pulse_start(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        start = 1'b1; size = sz; addr = a; wdata = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[0][i] = 32'h0;
            mem[1][i] = 32'h0;
        end
        mem_rdata[0] = 32'h5A5A_5A5A;
        mem_rdata[1] = 32'h5A5A_5A5A;
        reset = 1'b1; start = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", i, {31'd0, busy[i]}, 32'd0);
            chk("reset_done", i, {31'd0, done[i]}, 32'd0);
            chk("reset_mem_rd", i, {31'd0, mem_rd[i]}, 32'd0);
            chk("reset_mem_wr", i, {31'd0, mem_wr[i]}, 32'd0);
            chk("reset_mem_addr", i, mem_addr[i], 32'h0);
            chk("reset_mem_wdata", i, mem_wdata[i], 32'h0);
`ifdef STORE_RMW_ALIGN_CHECK_EN
            chk("reset_misalign", i, {31'd0, misalign[i]}, 32'd0);
`endif
        end
        reset = 1'b0;

        preset(32'h100, 32'hAABB_CCDD);
        issue(2'b00, 32'h102, 32'h0000_0011, 32'hAA11_CCDD, 1'b0, 1'b1);
        preset(32'h100, 32'hAABB_CCDD);
        issue(2'b01, 32'h100, 32'h0000_1234, 32'hAABB_1234, 1'b0, 1'b1);
        preset(32'h100, 32'hAABB_CCDD);
        issue(2'b01, 32'h102, 32'hFFFF_1234, 32'h1234_CCDD, 1'b0, 1'b1);

        // word store, with a start pulse landing in the DONE cycle
        issue(2'b10, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        pulse_start(2'b10, 32'h110, 32'h9999_9999);
        wait_idle();

        preset(32'h108, 32'h0123_4567);
        issue(2'b00, 32'h10B, 32'h9876_54AB, 32'hAB23_4567, 1'b0, 1'b1);
        preset(32'h108, 32'h0123_4567);
        issue(2'b00, 32'h108, 32'h0000_00CD, 32'h0123_45CD, 1'b0, 1'b1);

`ifdef STORE_RMW_ALIGN_CHECK_EN
        issue(2'b01, 32'h101, 32'h0000_BEEF, 32'h0, 1'b1, 1'b1);
        issue(2'b01, 32'h103, 32'h0000_BEEF, 32'h0, 1'b1, 1'b1);
`else
        preset(32'h100, 32'hAABB_CCDD);
        issue(2'b01, 32'h101, 32'h0000_BEEF, 32'hAABB_BEEF, 1'b0, 1'b1);
        preset(32'h100, 32'hAABB_CCDD);
        issue(2'b01, 32'h103, 32'h0000_BEEF, 32'hBEEF_CCDD, 1'b0, 1'b1);
`endif

        issue(2'b11, 32'h10E, 32'h0102_0304, 32'h0102_0304, 1'b0, 1'b1);

        // second start while busy must not create another access
        preset(32'h100, 32'hAABB_CCDD);
        issue(2'b00, 32'h101, 32'h0000_0042, 32'hAABB_42DD, 1'b0, 1'b0);
        pulse_start(2'b00, 32'h100, 32'h0000_0077);
        wait_idle();

        // reset while both DUTs sit in WAIT
        preset(32'h100, 32'hAABB_CCDD);
        issue(2'b00, 32'h101, 32'h0000_0033, 32'hAABB_33DD, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        sb[0].delete();
        sb[1].delete();
        rd_cnt = '{0, 0};
        wr_cnt = '{0, 0};
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_mid_busy", i, {31'd0, busy[i]}, 32'd0);
            chk("rst_mid_mem_wr", i, {31'd0, mem_wr[i]}, 32'd0);
            chk("rst_mid_done", i, {31'd0, done[i]}, 32'd0);
        end
        reset = 1'b0;
        rd_due = '{-1, -1};
        repeat (10) @(posedge clk);

        preset(32'h100, 32'hAABB_CCDD);
        issue(2'b01, 32'h102, 32'h0000_5678, 32'h5678_CCDD, 1'b0, 1'b1);

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
